// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle between the pipeline datapath
// and the hazard unit.
interface hazard_ctrl_if;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic [4:0]  rsE;
    logic [4:0]  rtE;
    logic        branchD;
    logic        jumpD;
    logic        branchTakenD;
    logic        mdUseD;
    logic        mdStartE;
    logic [4:0]  writeRegE;
    logic [4:0]  writeRegM;
    logic [4:0]  writeRegW;
    logic        Regfile_weE;
    logic        Regfile_weM;
    logic        Regfile_weW;
    logic [1:0]  regSrc_muxE;
    logic [1:0]  regSrc_muxM;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        flushE;
    logic [1:0]  forwardAE;
    logic [1:0]  forwardBE;
    logic        forwardAD;
    logic        forwardBD;
    logic        mdBusy;
    logic [31:0] stallCount;

    modport master (
        output rsD, rtD, rsE, rtE,
        output branchD, jumpD, branchTakenD,
        output mdUseD, mdStartE,
        output writeRegE, writeRegM, writeRegW,
        output Regfile_weE, Regfile_weM, Regfile_weW,
        output regSrc_muxE, regSrc_muxM,
        input  stallF, stallD, flushD, flushE,
        input  forwardAE, forwardBE,
        input  forwardAD, forwardBD,
        input  mdBusy, stallCount
    );

    modport slave (
        input  rsD, rtD, rsE, rtE,
        input  branchD, jumpD, branchTakenD,
        input  mdUseD, mdStartE,
        input  writeRegE, writeRegM, writeRegW,
        input  Regfile_weE, Regfile_weM, Regfile_weW,
        input  regSrc_muxE, regSrc_muxM,
        output stallF, stallD, flushD, flushE,
        output forwardAE, forwardBE,
        output forwardAD, forwardBD,
        output mdBusy, stallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding,
// mult/div busy tracking and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int         MD_LATENCY = 4,
    parameter logic [1:0] LOAD_SRC   = 2'b01
) (
    input  logic clk,
    input  logic rst,
    hazard_ctrl_if.slave hif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    mdState_t    state;
    mdState_t    stateNxt;
    logic [3:0]  cnt;
    logic [3:0]  cntNxt;
    logic [31:0] stallCnt;

    logic lwStall;
    logic brStall;
    logic mdStall;
    logic stall;
    logic eHitD;
    logic mLoadHitD;

    // EX operand forwarding, M result wins over W, r0 never forwarded
    always_comb begin
        hif.forwardAE = 2'b00;
        hif.forwardBE = 2'b00;
        if (hif.rsE != 5'd0) begin
            if (hif.Regfile_weM && hif.writeRegM == hif.rsE)
                hif.forwardAE = 2'b10;
            else if (hif.Regfile_weW && hif.writeRegW == hif.rsE)
                hif.forwardAE = 2'b01;
        end
        if (hif.rtE != 5'd0) begin
            if (hif.Regfile_weM && hif.writeRegM == hif.rtE)
                hif.forwardBE = 2'b10;
            else if (hif.Regfile_weW && hif.writeRegW == hif.rtE)
                hif.forwardBE = 2'b01;
        end
    end

    // ID comparator forwarding from the M ALU result
    always_comb begin
        hif.forwardAD = hif.Regfile_weM && hif.rsD != 5'd0
                        && hif.writeRegM == hif.rsD;
        hif.forwardBD = hif.Regfile_weM && hif.rtD != 5'd0
                        && hif.writeRegM == hif.rtD;
    end

    // stall sources, ORed into one hold/bubble signal
    always_comb begin
        eHitD = hif.Regfile_weE && hif.writeRegE != 5'd0
                && (hif.writeRegE == hif.rsD
                    || hif.writeRegE == hif.rtD);
        mLoadHitD = hif.Regfile_weM
                    && hif.regSrc_muxM == LOAD_SRC
                    && hif.writeRegM != 5'd0
                    && (hif.writeRegM == hif.rsD
                        || hif.writeRegM == hif.rtD);
        lwStall = eHitD && hif.regSrc_muxE == LOAD_SRC;
        brStall = hif.branchD && (eHitD || mLoadHitD);
        mdStall = hif.mdUseD && (hif.mdBusy || hif.mdStartE);
        stall   = lwStall | brStall | mdStall;
    end

    // stall/flush outputs; a stalled redirect waits for its operands
    always_comb begin
        hif.stallF = stall;
        hif.stallD = stall;
        hif.flushE = stall;
        hif.flushD = ((hif.branchD && hif.branchTakenD)
                      || hif.jumpD) && !stall;
    end

    // mult/div busy FSM state and down-counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
        end
    end

    // mult/div next state; an issue while busy is ignored
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        unique case (state)
            IDLE: begin
                if (hif.mdStartE) begin
                    stateNxt = BUSY;
                    cntNxt   = 4'(MD_LATENCY - 1);
                end
            end
            BUSY: begin
                cntNxt = cnt - 4'd1;
                if (cnt == 4'd1)
                    stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
                cntNxt   = 4'd0;
            end
        endcase
    end

    // busy flag straight from the state so reset drops it at once
    always_comb begin
        hif.mdBusy = (state == BUSY);
    end

    // saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stallCnt <= 32'd0;
        else if (stall && stallCnt != 32'hFFFF_FFFF)
            stallCnt <= stallCnt + 32'd1;
    end

    // counter export
    always_comb begin
        hif.stallCount = stallCnt;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus
// hand-written multi-cycle sequences.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   nVec;
    int   nBad;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .MD_LATENCY (4),
        .LOAD_SRC   (2'b01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rsD, rtD, rsE, rtE;
        logic [4:0] wrE, wrM, wrW;
        logic       weE, weM, weW;
        logic [1:0] srcE, srcM;
        logic       brD, tak, jmp, mdU, mdS;
        logic       xStall, xFlD;
        logic [1:0] xFAE, xFBE;
        logic       xFAD, xFBD;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic clearIn();
        hif.rsD = 0; hif.rtD = 0; hif.rsE = 0; hif.rtE = 0;
        hif.writeRegE = 0; hif.writeRegM = 0; hif.writeRegW = 0;
        hif.Regfile_weE = 0; hif.Regfile_weM = 0;
        hif.Regfile_weW = 0;
        hif.regSrc_muxE = 0; hif.regSrc_muxM = 0;
        hif.branchD = 0; hif.branchTakenD = 0; hif.jumpD = 0;
        hif.mdUseD = 0; hif.mdStartE = 0;
    endtask

    task automatic applyVec(input vec_t v);
        hif.rsD = v.rsD; hif.rtD = v.rtD;
        hif.rsE = v.rsE; hif.rtE = v.rtE;
        hif.writeRegE = v.wrE; hif.writeRegM = v.wrM;
        hif.writeRegW = v.wrW;
        hif.Regfile_weE = v.weE; hif.Regfile_weM = v.weM;
        hif.Regfile_weW = v.weW;
        hif.regSrc_muxE = v.srcE; hif.regSrc_muxM = v.srcM;
        hif.branchD = v.brD; hif.branchTakenD = v.tak;
        hif.jumpD = v.jmp;
        hif.mdUseD = v.mdU; hif.mdStartE = v.mdS;
    endtask

    task automatic loadUse5();
        clearIn();
        hif.rsD = 5'd5;
        hif.writeRegE = 5'd5;
        hif.Regfile_weE = 1'b1;
        hif.regSrc_muxE = 2'b01;
    endtask

    task automatic doReset();
        rst = 1'b0;
        clearIn();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        nVec = 0;
        nBad = 0;
        rst  = 1'b0;
        clearIn();

        // rsD rtD rsE rtE wrE wrM wrW weE weM weW srcE srcM
        // br tak jmp mdU mdS | stall flD fAE fBE fAD fBD
        tbl[0]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,
                    0,0,0,0,0,0};
        tbl[1]  = '{5,0,0,0,5,0,0,1,0,0,1,0,0,0,0,0,0,
                    1,0,0,0,0,0};
        tbl[2]  = '{0,0,0,0,0,0,0,1,0,0,1,0,0,0,0,0,0,
                    0,0,0,0,0,0};
        tbl[3]  = '{0,9,0,0,9,0,0,1,0,0,1,0,0,0,0,0,0,
                    1,0,0,0,0,0};
        tbl[4]  = '{5,0,0,0,5,0,0,1,0,0,0,0,0,0,0,0,0,
                    0,0,0,0,0,0};
        tbl[5]  = '{0,0,3,0,0,3,3,0,1,1,0,0,0,0,0,0,0,
                    0,0,2,0,0,0};
        tbl[6]  = '{0,0,3,0,0,3,3,0,0,1,0,0,0,0,0,0,0,
                    0,0,1,0,0,0};
        tbl[7]  = '{0,0,0,0,0,0,0,0,1,1,0,0,0,0,0,0,0,
                    0,0,0,0,0,0};
        tbl[8]  = '{0,0,6,4,0,4,6,0,1,1,0,0,0,0,0,0,0,
                    0,0,1,2,0,0};
        tbl[9]  = '{0,7,0,0,7,0,0,1,0,0,0,0,1,1,0,0,0,
                    1,0,0,0,0,0};
        tbl[10] = '{0,7,0,0,0,7,0,0,1,0,0,0,1,1,0,0,0,
                    0,1,0,0,0,1};
        tbl[11] = '{8,0,0,0,0,8,0,0,1,0,0,1,1,1,0,0,0,
                    1,0,0,0,1,0};
        tbl[12] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,
                    0,1,0,0,0,0};
        tbl[13] = '{5,0,0,0,5,0,0,1,0,0,1,0,0,0,1,0,0,
                    1,0,0,0,0,0};
        tbl[14] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,
                    1,0,0,0,0,0};
        tbl[15] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,
                    0,0,0,0,0,0};
        tbl[16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,
                    0,0,0,0,0,0};
        tbl[17] = '{5,0,0,0,5,0,0,0,0,0,1,0,0,0,0,0,0,
                    0,0,0,0,0,0};
        tbl[18] = '{8,0,0,0,0,8,0,0,1,0,0,1,0,0,0,0,0,
                    0,0,0,0,1,0};

        // reset-state outputs with all inputs low
        #1;
        check("rst mdBusy", 32'(hif.mdBusy), 0);
        check("rst stallCount", hif.stallCount, 0);
        check("rst stallD", 32'(hif.stallD), 0);
        check("rst flushD", 32'(hif.flushD), 0);

        // combinational table, held in reset so no state moves
        for (int i = 0; i < 19; i++) begin
            applyVec(tbl[i]);
            #1;
            check($sformatf("v%0d stallF", i),
                  32'(hif.stallF), 32'(tbl[i].xStall));
            check($sformatf("v%0d stallD", i),
                  32'(hif.stallD), 32'(tbl[i].xStall));
            check($sformatf("v%0d flushE", i),
                  32'(hif.flushE), 32'(tbl[i].xStall));
            check($sformatf("v%0d flushD", i),
                  32'(hif.flushD), 32'(tbl[i].xFlD));
            check($sformatf("v%0d fwdAE", i),
                  32'(hif.forwardAE), 32'(tbl[i].xFAE));
            check($sformatf("v%0d fwdBE", i),
                  32'(hif.forwardBE), 32'(tbl[i].xFBE));
            check($sformatf("v%0d fwdAD", i),
                  32'(hif.forwardAD), 32'(tbl[i].xFAD));
            check($sformatf("v%0d fwdBD", i),
                  32'(hif.forwardBD), 32'(tbl[i].xFBD));
        end

        // load-use: one stalled cycle counted
        doReset();
        @(negedge clk);
        loadUse5();
        #1;
        check("lu stallD", 32'(hif.stallD), 1);
        @(negedge clk);
        clearIn();
        #1;
        check("lu stallD after", 32'(hif.stallD), 0);
        check("lu count", hif.stallCount, 1);

        // jump held through a stall, flushes once unstalled
        loadUse5();
        hif.jumpD = 1'b1;
        #1;
        check("jmp stalled flushD", 32'(hif.flushD), 0);
        @(negedge clk);
        clearIn();
        hif.jumpD = 1'b1;
        #1;
        check("jmp flushD", 32'(hif.flushD), 1);
        check("jmp count", hif.stallCount, 2);

        // mult/div: busy 3 cycles, stall 4 cycles
        doReset();
        @(negedge clk);
        hif.mdUseD = 1'b1;
        hif.mdStartE = 1'b1;
        #1;
        check("md c0 stall", 32'(hif.stallD), 1);
        check("md c0 busy", 32'(hif.mdBusy), 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            hif.mdStartE = 1'b0;
            #1;
            check($sformatf("md c%0d busy", c),
                  32'(hif.mdBusy), 1);
            check($sformatf("md c%0d stall", c),
                  32'(hif.stallD), 1);
        end
        @(negedge clk);
        #1;
        check("md c4 busy", 32'(hif.mdBusy), 0);
        check("md c4 stall", 32'(hif.stallD), 0);
        check("md count", hif.stallCount, 4);
        @(negedge clk);
        #1;
        check("md count hold", hif.stallCount, 4);

        // reset in the middle of BUSY acts without a clock edge
        doReset();
        @(negedge clk);
        hif.mdUseD = 1'b1;
        hif.mdStartE = 1'b1;
        @(negedge clk);
        hif.mdStartE = 1'b0;
        #1;
        check("mr busy", 32'(hif.mdBusy), 1);
        check("mr count", hif.stallCount, 1);
        #1;
        rst = 1'b0;
        #1;
        check("mr busy async", 32'(hif.mdBusy), 0);
        check("mr count async", hif.stallCount, 0);
        clearIn();
        @(negedge clk);
        rst = 1'b1;

        // saturation from a preloaded near-full count
        @(negedge clk);
        loadUse5();
        force dut.stallCnt = 32'hFFFF_FFFE;
        #1;
        release dut.stallCnt;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("sat c%0d", c),
                  hif.stallCount, 32'hFFFF_FFFF);
        end
        clearIn();

        $display("== %0d vectors applied, %0d miscompares ==",
                 nVec, nBad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sequences the ID/EX pipeline register by driving `flushE`, holds the fetch and decode stages on a stall, and selects operand forwarding for the EX-stage ALU and the ID-stage branch comparator. It also owns a busy tracker for the multi-cycle multiply/divide unit and a saturating stall-cycle performance counter.

## Interface
- `MD_LATENCY`, default 4: number of cycles the mult/div unit stays busy after issue; legal range 2..15.
- `LOAD_SRC`, default 2'b01: `regSrc_mux` encoding that selects memory data, which identifies a load.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset. Asynchronous and active-low.
- `rsD`, `rtD`  in  5 each: source registers in decode.
- `rsE`, `rtE`  in  5 each: source registers in execute.
- `branchD`, `jumpD`  in  1 each: a branch or jump is in decode.
- `branchTakenD`  in  1: branch comparison result in decode, using forwarded operands.
- `mdUseD`  in  1: the decode instruction is a mult/div or reads HI/LO.
- `mdStartE`  in  1: a mult/div is issuing from execute this cycle.
- `writeRegE`, `writeRegM`, `writeRegW`  in  5 each: destination register per stage.
- `Regfile_weE`, `Regfile_weM`, `Regfile_weW`  in  1 each: register-file write enable per stage.
- `regSrc_muxE`, `regSrc_muxM`  in  2 each: writeback source select per stage.
- `stallF`, `stallD`  out  1 each: hold the PC and the IF/ID register.
- `flushD`  out  1: clear the IF/ID register.
- `flushE`  out  1: drives the ID/EX `flushE` input and inserts a bubble.
- `forwardAE`, `forwardBE`  out  2 each: EX operand select. 00 = register file, 01 = W result, 10 = M ALU result.
- `forwardAD`, `forwardBD`  out  1 each: ID comparator takes the M ALU result.
- `mdBusy`  out  1: the mult/div unit is busy.
- `stallCount`  out  32: count of cycles in which `stallD` was high; saturates at 32'hFFFFFFFF.

## Operation
- **Forwarding** (combinational). Register 0 is never forwarded.
  - `forwardAE` = 10 if `Regfile_weM` && `writeRegM` == `rsE`.
  - Otherwise `forwardAE` = 01 if `Regfile_weW` && `writeRegW` == `rsE`.
  - Otherwise `forwardAE` = 00.
  - M has priority over W. `forwardBE` is the same rule applied to `rtE`.
  - `forwardAD` = `Regfile_weM` && `writeRegM` == `rsD` && `rsD` != 0. `forwardBD` is the same rule applied to `rtD`.
- **Load-use stall** (`lwStall`): `Regfile_weE` && `regSrc_muxE` == `LOAD_SRC` && `writeRegE` != 0 && (`writeRegE` == `rsD` || `writeRegE` == `rtD`).
- **Branch stall** (`brStall`): `branchD` && (E stage writes a nonzero `rsD`/`rtD`, or M stage is a load (`regSrc_muxM` == `LOAD_SRC`) that writes a nonzero `rsD`/`rtD`).
- **Mult/div stall** (`mdStall`): `mdUseD` && (`mdBusy` || `mdStartE`).
- **Stall outputs**: `stallF` = `stallD` = `flushE` = `lwStall` | `brStall` | `mdStall`.
- **Redirect flush**: `flushD` = (`branchD` && `branchTakenD` || `jumpD`) && !`stallD`. A stalled branch does not flush.
- **Mult/div FSM**: two states, IDLE and BUSY, with a down-counter `cnt` of 4 bits.
  - IDLE: on `mdStartE`, go to BUSY and set `cnt` = `MD_LATENCY` − 1.
  - BUSY: decrement `cnt` each cycle. When `cnt` == 1, return to IDLE next cycle.
  - `mdBusy` is high exactly when in BUSY, so it is high for `MD_LATENCY` − 1 cycles after the issue cycle. Including the issue cycle, the unit is busy for `MD_LATENCY` cycles.
  - `mdStartE` while in BUSY is impossible by construction, because `mdStall` prevents it. If it occurs anyway it is ignored.
- **stallCount**: increments on every `clk` edge where `stallD` is 1. It holds at all ones once saturated.

## Timing
- All stall, flush and forward outputs are combinational from the same-cycle inputs. They have zero latency.
- FSM state, `cnt` and `stallCount` update on the rising edge of `clk`.
- Reset values on `rst` low, applied immediately and asynchronously:
  - State = IDLE, `cnt` = 0, `mdBusy` = 0, `stallCount` = 0.
  - The combinational outputs follow their inputs. With all inputs 0 they are `stallF`/`stallD`/`flushD`/`flushE` = 0 and `forward*` = 0.
- Reset asserted while the FSM is in BUSY aborts the operation: `mdBusy` drops in the same cycle.
- Deassertion of `rst` is assumed synchronous to `clk` by the system reset logic.
- A load-use stall lasts 1 cycle. A branch stall lasts 1 cycle for an ALU producer in E, 1 more for a load producer (2 total), and 1 cycle for a load producer in M.
- Simultaneous stall sources are ORed; they do not add. `stallCount` increments by one per stalled cycle.
- A `jumpD` that coincides with any stall waits; `flushD` asserts in the first unstalled cycle.

## Test plan
- Load-use: E holds a load to r5 (`regSrc_muxE` = 01, `Regfile_weE` = 1), `rsD` = 5 → `stallF`/`stallD`/`flushE` = 1 for 1 cycle and `stallCount` = 1. With `writeRegE` = 0, no stall.
- Forward priority: M writes r3 and W writes r3, `rsE` = 3 → `forwardAE` = 10. M write disabled → 01. `rsE` = 0 → 00.
- Branch: `branchD` = 1, `rtD` = 7, E writes r7 via the ALU → stall 1 cycle. Then with M writing r7, `forwardBD` = 1, `branchTakenD` = 1 → `flushD` = 1 and `stallD` = 0.
- Mult/div with `MD_LATENCY` = 4: pulse `mdStartE` with `mdUseD` = 1 held → `mdBusy` high for 3 cycles and `stallD` high for 4 cycles. The stall clears the cycle after `mdBusy` falls, and `stallCount` = 4.
- Reset mid-BUSY: drive `rst` low 1 cycle after `mdStartE` → `mdBusy` = 0 and `stallCount` = 0 immediately, with no clock edge required.
- Saturation: preload `stallCount` to 32'hFFFFFFFE (force), stall 3 cycles → reads 32'hFFFFFFFF and holds.
